instr_stream_encoder: RTL and testbench

INSTR_STREAM_ENCODER -- requirements
Module: instr_stream_encoder

---
 rtl/instr_stream_encoder.sv | 159 +++++++++++++++
 tb/tb_instr_stream_encoder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_encoder.sv
// Packs field bundles into instruction words and streams them to instruction memory.
// Define ENCODER_CLASS_CHECK_EN to drop bundles whose IsScalar disagrees with Register[2].
module instr_stream_encoder #(
    parameter int N      = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic              FieldValid,
    output logic              FieldReady,
    input  logic [3:0]        Opcode,
    input  logic [3:0]        Register,
    input  logic [7:0]        Immediate,
    input  logic              IsScalar,
    input  logic              Last,
    output logic              MemWriteEn,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [N-1:0]      MemData,
    input  logic              MemReady,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [ADDR_W-1:0] WordCount
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]      fifo_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic [ADDR_W-1:0] addr_ptr_q;

    logic          fifo_empty, fifo_full;
    logic          handshake, class_ok, push;
    logic          slot_free, write_acc, pop;
    logic          bypass, push_fifo, pop_fifo;
    logic          start_ok;
    logic [N-1:0]  in_word;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);

    assign FieldReady = (state_q == LOAD) && !fifo_full;
    assign Busy       = (state_q != IDLE);
    assign Done       = (state_q == DONE);

    assign handshake = FieldValid && FieldReady;
    assign push      = handshake && class_ok;
    assign in_word   = N'({Opcode, Register, Immediate});
    assign start_ok  = Start && (state_q == IDLE);

    // An empty FIFO lets the incoming word go straight to the write port.
    assign slot_free = !MemWriteEn || MemReady;
    assign write_acc = MemWriteEn && MemReady;
    assign pop       = slot_free && (!fifo_empty || push);
    assign bypass    = pop && fifo_empty;
    assign push_fifo = push && !bypass;
    assign pop_fifo  = pop && !fifo_empty;

`ifdef ENCODER_CLASS_CHECK_EN
    assign class_ok = (IsScalar == Register[2]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Error <= 1'b0;
        end else if (start_ok) begin
            Error <= 1'b0;
        end else if (handshake && !class_ok) begin
            Error <= 1'b1;
        end
    end
`else
    logic unused_class;
    assign unused_class = IsScalar;
    assign class_ok     = 1'b1;
    assign Error        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Start) state_d = LOAD;
            LOAD:    if (handshake && Last) state_d = DRAIN;
            DRAIN:   if (fifo_empty && slot_free) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_fifo) begin
            fifo_q[wr_ptr_q] <= in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_ptr_q <= '0;
            MemWriteEn <= 1'b0;
            MemAddr    <= '0;
            MemData    <= '0;
            WordCount  <= '0;
        end else begin
            if (push_fifo) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_fifo) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_fifo && !pop_fifo) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!push_fifo && pop_fifo) begin
                count_q <= count_q - (AW+1)'(1);
            end

            if (start_ok) begin
                WordCount  <= '0;
                addr_ptr_q <= BaseAddr;
            end else if (write_acc) begin
                WordCount <= WordCount + ADDR_W'(1);
            end

            // Each popped word takes the next address, so MemAddr tracks Base+WordCount.
            if (pop) begin
                MemWriteEn <= 1'b1;
                MemData    <= fifo_empty ? in_word : fifo_q[rd_ptr_q];
                MemAddr    <= addr_ptr_q;
                addr_ptr_q <= addr_ptr_q + ADDR_W'(1);
            end else if (write_acc) begin
                MemWriteEn <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Randomized bench for instr_stream_encoder with a queue-based reference model.
// Model follows ENCODER_CLASS_CHECK_EN the same way the design does.
module tb_instr_stream_encoder;

    localparam int N      = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              Start = 1'b0;
    logic [ADDR_W-1:0] BaseAddr = '0;
    logic              FieldValid = 1'b0;
    logic              FieldReady;
    logic [3:0]        Opcode = '0;
    logic [3:0]        Register = '0;
    logic [7:0]        Immediate = '0;
    logic              IsScalar = 1'b0;
    logic              Last = 1'b0;
    logic              MemWriteEn;
    logic [ADDR_W-1:0] MemAddr;
    logic [N-1:0]      MemData;
    logic              MemReady = 1'b1;
    logic              Busy;
    logic              Done;
    logic              Error;
    logic [ADDR_W-1:0] WordCount;

    instr_stream_encoder #(.N(N), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .BaseAddr(BaseAddr),
        .FieldValid(FieldValid), .FieldReady(FieldReady),
        .Opcode(Opcode), .Register(Register), .Immediate(Immediate),
        .IsScalar(IsScalar), .Last(Last),
        .MemWriteEn(MemWriteEn), .MemAddr(MemAddr), .MemData(MemData),
        .MemReady(MemReady), .Busy(Busy), .Done(Done), .Error(Error),
        .WordCount(WordCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit dropped(input logic [3:0] r, input logic s);
`ifdef ENCODER_CLASS_CHECK_EN
        return s != r[2];
`else
        return 1'b0;
`endif
    endfunction

    // reference model state
    logic [15:0] exp_q[$];
    int          exp_wc = 0;
    logic [7:0]  m_base = '0;
    bit          exp_err = 0;
    bit          hold_chk = 0;
    logic [7:0]  h_addr;
    logic [15:0] h_data;
    logic [15:0] log_d[$];
    logic [7:0]  log_a[$];
    int          done_cnt = 0;
    int          cyc = 0;
    int          first_acc = -1;
    int          first_wr = -1;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            exp_wc   = 0;
            exp_err  = 0;
            hold_chk = 0;
        end else begin
            chk("word_count", WordCount, exp_wc[7:0]);
            chk("error", Error, exp_err);
            if (hold_chk) begin
                chk("hold_en", MemWriteEn, 1);
                chk("hold_addr", MemAddr, h_addr);
                chk("hold_data", MemData, h_data);
            end
            if (MemWriteEn && first_wr < 0) first_wr = cyc;
            if (MemWriteEn && MemReady) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", MemData, 32'hdead_0000);
                end else begin
                    chk("wr_data", MemData, exp_q.pop_front());
                    chk("wr_addr", MemAddr, 8'(m_base + 8'(exp_wc)));
                end
                log_d.push_back(MemData);
                log_a.push_back(MemAddr);
                exp_wc++;
            end
            hold_chk = MemWriteEn && !MemReady;
            h_addr   = MemAddr;
            h_data   = MemData;
            if (Done) begin
                done_cnt++;
                chk("done_drained", exp_q.size(), 0);
            end
            if (Start && !Busy) begin
                m_base  = BaseAddr;
                exp_wc  = 0;
                exp_err = 0;
                exp_q.delete();
                log_d.delete();
                log_a.delete();
                done_cnt  = 0;
                first_acc = -1;
                first_wr  = -1;
            end
            if (FieldValid && FieldReady) begin
                if (first_acc < 0) first_acc = cyc;
                if (dropped(Register, IsScalar)) exp_err = 1;
                else exp_q.push_back({Opcode, Register, Immediate});
            end
        end
    end

    logic [3:0] b_op[16];
    logic [3:0] b_rg[16];
    logic [7:0] b_im[16];
    logic       b_sc[16];
    int         stall_acc;
    logic       fr_at_stall;

    task automatic fill_random(input int n, input bit flips);
        for (int k = 0; k < n; k++) begin
            b_op[k] = 4'($urandom);
            b_rg[k] = 4'($urandom);
            b_im[k] = 8'($urandom);
            b_sc[k] = b_rg[k][2];
            if (flips && $urandom_range(0, 5) == 0) b_sc[k] = ~b_sc[k];
        end
    endtask

    // mode 0: ready/valid always high; 1: random; 2: MemReady low for 10 cycles
    task automatic run_session(input logic [7:0] base, input int n, input int mode);
        int  i, it, st;
        bit  acc, seen;
        @(posedge clk); #1;
        Start    = 1'b1;
        BaseAddr = base;
        MemReady = (mode != 2);
        @(posedge clk); #1;
        Start    = 1'b0;
        BaseAddr = 8'($urandom);
        i = 0; it = 0; st = 0; stall_acc = 0; fr_at_stall = 1'b1;
        while (i < n && it < 2000) begin
            FieldValid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            Opcode     = b_op[i];
            Register   = b_rg[i];
            Immediate  = b_im[i];
            IsScalar   = b_sc[i];
            Last       = (i == n - 1);
            if (mode == 1) MemReady = ($urandom_range(0, 2) != 0);
            else if (mode == 2) MemReady = (st >= 10);
            @(negedge clk);
            acc = FieldValid && FieldReady;
            if (mode == 2 && !MemReady && acc) stall_acc++;
            if (mode == 2 && st == 9) fr_at_stall = FieldReady;
            @(posedge clk); #1;
            if (acc) i++;
            st++;
            it++;
        end
        FieldValid = 1'b0;
        Last       = 1'b0;
        seen = 0;
        it   = 0;
        while (!seen && it < 300) begin
            MemReady = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            seen = Done;
            @(posedge clk); #1;
            it++;
        end
        MemReady = 1'b1;
        chk("session_done", seen, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wen", MemWriteEn, 0);
        chk("rst_fready", FieldReady, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_addr", MemAddr, 0);
        chk("rst_data", MemData, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // basic write
        b_op[0] = 4'hC; b_rg[0] = 4'h4; b_im[0] = 8'h3A; b_sc[0] = 1'b1;
        b_op[1] = 4'h1; b_rg[1] = 4'h2; b_im[1] = 8'h05; b_sc[1] = 1'b0;
        b_op[2] = 4'h8; b_rg[2] = 4'h5; b_im[2] = 8'hFF; b_sc[2] = 1'b1;
        run_session(8'h10, 3, 0);
        chk("basic_nwr", log_d.size(), 3);
        if (log_d.size() == 3) begin
            chk("basic_d0", log_d[0], 16'hC43A);
            chk("basic_a0", log_a[0], 8'h10);
            chk("basic_d1", log_d[1], 16'h1205);
            chk("basic_a1", log_a[1], 8'h11);
            chk("basic_d2", log_d[2], 16'h85FF);
            chk("basic_a2", log_a[2], 8'h12);
        end
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_latency", first_wr - first_acc, 1);
        @(negedge clk);
        chk("basic_wc_hold", WordCount, 3);
        chk("basic_idle", Busy, 0);

        // back-pressure
        fill_random(8, 0);
        run_session(8'h20, 8, 2);
        chk("bp_accepts", stall_acc, DEPTH + 1);
        chk("bp_fready_low", fr_at_stall, 0);
        chk("bp_nwr", log_d.size(), 8);
        if (log_d.size() == 8) chk("bp_last", log_d[7], {b_op[7], b_rg[7], b_im[7]});

        // address wrap
        fill_random(4, 0);
        run_session(8'hFE, 4, 0);
        chk("wrap_nwr", log_a.size(), 4);
        if (log_a.size() == 4) begin
            chk("wrap_a0", log_a[0], 8'hFE);
            chk("wrap_a1", log_a[1], 8'hFF);
            chk("wrap_a2", log_a[2], 8'h00);
            chk("wrap_a3", log_a[3], 8'h01);
        end

        // class mismatch in the middle bundle
        b_op[0] = 4'h2; b_rg[0] = 4'h4; b_im[0] = 8'h11; b_sc[0] = 1'b1;
        b_op[1] = 4'h3; b_rg[1] = 4'h3; b_im[1] = 8'h22; b_sc[1] = 1'b1;
        b_op[2] = 4'h4; b_rg[2] = 4'h6; b_im[2] = 8'h33; b_sc[2] = 1'b1;
        run_session(8'h30, 3, 0);
        @(negedge clk);
`ifdef ENCODER_CLASS_CHECK_EN
        chk("cls_nwr", log_d.size(), 2);
        chk("cls_err", Error, 1);
        chk("cls_wc", WordCount, 2);
`else
        chk("cls_nwr", log_d.size(), 3);
        chk("cls_err", Error, 0);
        chk("cls_wc", WordCount, 3);
`endif

        // randomized sessions
        for (int s = 0; s < 20; s++) begin
            int n;
            n = $urandom_range(1, 12);
            fill_random(n, 1);
            run_session(8'($urandom), n, 1);
        end

        // reset while draining with a write pending
        fill_random(3, 0);
        @(posedge clk); #1;
        Start = 1'b1; BaseAddr = 8'h40; MemReady = 1'b0;
        @(posedge clk); #1;
        Start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int guard;
            bit acc;
            FieldValid = 1'b1;
            Opcode = b_op[k]; Register = b_rg[k]; Immediate = b_im[k];
            IsScalar = b_sc[k]; Last = (k == 2);
            acc = 0;
            guard = 0;
            while (!acc && guard < 20) begin
                @(negedge clk);
                acc = FieldValid && FieldReady;
                @(posedge clk); #1;
                guard++;
            end
        end
        FieldValid = 1'b0;
        Last = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_busy", Busy, 1);
        chk("pre_rst_wen", MemWriteEn, 1);
        chk("pre_rst_fready", FieldReady, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_wen", MemWriteEn, 0);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_addr", MemAddr, 0);
        chk("mid_rst_data", MemData, 0);
        chk("mid_rst_wc", WordCount, 0);
        chk("mid_rst_fready", FieldReady, 0);
        chk("mid_rst_done", Done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        MemReady = 1'b1;
        fill_random(2, 0);
        run_session(8'h50, 2, 0);
        chk("post_rst_nwr", log_d.size(), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
